// File: rtl/dec_sel_if.sv
// Handshake/bus bundle between the select sequencer and its controller/consumer.
// DEC_SEL_ONEHOT_EN adds the registered onehot cross-check output.
interface dec_sel_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         mask;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic               wrap;
  logic               done;
  logic               err;
`ifdef DEC_SEL_ONEHOT_EN
  logic [7:0]         onehot;

  modport master (
    output start, stop, mode, dwell, mask,
    input  sel, sel_valid, busy, wrap, done, err, onehot
  );

  modport slave (
    input  start, stop, mode, dwell, mask,
    output sel, sel_valid, busy, wrap, done, err, onehot
  );
`else
  modport master (
    output start, stop, mode, dwell, mask,
    input  sel, sel_valid, busy, wrap, done, err
  );

  modport slave (
    input  start, stop, mode, dwell, mask,
    output sel, sel_valid, busy, wrap, done, err
  );
`endif
endinterface

// File: rtl/dec_sel_sequencer.sv
// Steps a 3-bit decoder select through a latched mask, holding each value for dwell cycles.
// Latency start->sel_valid 1 cycle; all outputs registered. Optional DEC_SEL_ONEHOT_EN adds onehot.
module dec_sel_sequencer #(
  parameter int DWELL_W = 8,
  parameter int MASK_W  = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  dec_sel_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] in_reload;
  logic               hi_found;
  logic [2:0]         hi_sel;

  function automatic logic [2:0] lowest_bit(input logic [MASK_W-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Counter reload is eff_dwell-1, with a zero dwell treated as one cycle.
  assign in_reload = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        hi_found = 1'b1;
        hi_sel   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mask_d      = mask_q;
    mode_d      = mode_q;
    reload_d    = reload_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.mask != '0) begin
            mask_d      = bus.mask;
            mode_d      = bus.mode;
            reload_d    = in_reload;
            cnt_d       = in_reload;
            sel_d       = lowest_bit(bus.mask);
            sel_valid_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stop outranks a coincident slot expiry, so no wrap/done on abort.
        if (bus.stop) begin
          state_d     = ST_IDLE;
          sel_d       = '0;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (hi_found) begin
          sel_d = hi_sel;
          cnt_d = reload_q;
        end else if (!mode_q) begin
          sel_d  = lowest_bit(mask_q);
          wrap_d = 1'b1;
          cnt_d  = reload_q;
        end else begin
          state_d     = ST_IDLE;
          sel_d       = '0;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      reload_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      reload_q    <= reload_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef DEC_SEL_ONEHOT_EN
  logic [7:0] onehot_q, onehot_d;

  assign onehot_d = sel_valid_d ? (8'h01 << sel_d) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) onehot_q <= 8'h00;
    else        onehot_q <= onehot_d;
  end

  assign bus.onehot = onehot_q;
`endif

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed bench for dec_sel_sequencer: single pass, wrap, zero dwell, empty mask, stop priority, async reset.
module tb_dec_sel_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dec_sel_if #(.DWELL_W(8)) bus ();

  dec_sel_sequencer #(.DWELL_W(8), .MASK_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"},   32'(bus.sel), 32'd0);
    check({tag, "_vld"},   32'(bus.sel_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
`ifdef DEC_SEL_ONEHOT_EN
    check({tag, "_onehot"}, 32'(bus.onehot), 32'd0);
`endif
  endtask

  task automatic check_slot(input string tag, input logic [2:0] exp_sel, input logic exp_wrap);
    check({tag, "_sel"},  32'(bus.sel), 32'(exp_sel));
    check({tag, "_vld"},  32'(bus.sel_valid), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_wrap"}, 32'(bus.wrap), 32'(exp_wrap));
    check({tag, "_done"}, 32'(bus.done), 32'd0);
`ifdef DEC_SEL_ONEHOT_EN
    begin
      logic [7:0] exp_oh;
      exp_oh = 8'h01 << exp_sel;
      check({tag, "_onehot"}, 32'(bus.onehot), 32'(exp_oh));
    end
`endif
  endtask

  task automatic start_scan(input logic [7:0] m, input logic [7:0] d, input logic md);
    bus.mask  = m;
    bus.dwell = d;
    bus.mode  = md;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [2:0] sp_exp [9];
    sp_exp = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 1'b0;
    bus.dwell = '0;
    bus.mask  = '0;
    tick();
    tick();
    check_idle("rst");
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;
    tick();

    // Single pass; inputs scrambled mid-run must not matter.
    start_scan(8'b1010_0100, 8'd3, 1'b1);
    bus.mask  = 8'hFF;
    bus.dwell = 8'd1;
    bus.mode  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check_slot($sformatf("sp%0d", i), sp_exp[i], 1'b0);
      if (i == 4) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    check_idle("sp_end");
    check("sp_done", 32'(bus.done), 32'd1);
    check("sp_wrap", 32'(bus.wrap), 32'd0);
    tick();
    check("sp_done_clr", 32'(bus.done), 32'd0);
    check_idle("sp_after");

    // Continuous wrap over all 8 lines, three passes.
    start_scan(8'hFF, 8'd1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      check_slot($sformatf("cw%0d", i), 3'(i % 8), (i > 0) && (i % 8 == 0));
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("cw_stop");
    check("cw_stop_wrap", 32'(bus.wrap), 32'd0);
    check("cw_stop_done", 32'(bus.done), 32'd0);
    tick();

    // Zero dwell behaves as one; single bit wraps every cycle.
    start_scan(8'b0100_0000, 8'd0, 1'b0);
    check_slot("dz0", 3'd6, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_slot($sformatf("dz%0d", i), 3'd6, 1'b1);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("dz_stop");
    tick();

    // Empty mask.
    start_scan(8'h00, 8'd4, 1'b0);
    check("em_err",  32'(bus.err),  32'd1);
    check("em_busy", 32'(bus.busy), 32'd0);
    check("em_vld",  32'(bus.sel_valid), 32'd0);
    tick();
    check("em_err_clr", 32'(bus.err), 32'd0);
    check("em_busy2",   32'(bus.busy), 32'd0);

    // Stop together with start on the expiry cycle of the last slot.
    start_scan(8'b0010_0000, 8'd2, 1'b1);
    check_slot("sp_pri0", 3'd5, 1'b0);
    tick();
    check_slot("sp_pri1", 3'd5, 1'b0);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    check_idle("pri");
    check("pri_done", 32'(bus.done), 32'd0);
    check("pri_wrap", 32'(bus.wrap), 32'd0);
    tick();
    check_idle("pri_after");
    check("pri_done2", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of a slot.
    start_scan(8'b0010_0000, 8'd10, 1'b0);
    check_slot("ar_pre", 3'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("ar");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("ar_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
